// File: rtl/sample_feeder.sv
`default_nettype none
// ============================================================================
// Module      : sample_feeder
// Description : Sample FIFO plus 4-slot coefficient shadow bank feeding a
//               downstream filter through a data_ready/load_coeff request,
//               modwait busy handshake. Optional macro
//               SAMPLE_FEEDER_DROP_CNT_EN builds a saturating drop counter.
// Revision    : 1.0 - initial release
// ============================================================================
module sample_feeder #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [15:0]              in_data,
    output logic                     in_ready,
    input  logic                     coeff_wr,
    input  logic [1:0]               coeff_idx,
    input  logic [15:0]              coeff_data,
    input  logic                     coeff_go,
    input  logic                     modwait,
    output logic [15:0]              sample_data,
    output logic [15:0]              fir_coefficient,
    output logic                     data_ready,
    output logic                     load_coeff,
    output logic [$clog2(DEPTH):0]   fill_level,
    output logic                     coeff_busy,
    output logic                     overrun,
    output logic [7:0]               drop_count
);

    localparam int                   c_ADDR_W  = $clog2(DEPTH);
    localparam logic [c_ADDR_W:0]    c_FULL    = (c_ADDR_W+1)'(DEPTH);
    localparam logic [c_ADDR_W-1:0]  c_PTR_ONE = {{(c_ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [c_ADDR_W:0]    c_CNT_ONE = {{c_ADDR_W{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_LWAIT = 3'd2,
        S_ISSUE = 3'd3,
        S_SWAIT = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [15:0]           r_mem [DEPTH];
    logic [c_ADDR_W-1:0]   r_wr_ptr;
    logic [c_ADDR_W-1:0]   r_rd_ptr;
    logic [c_ADDR_W:0]     r_count;
    logic [15:0]           r_slot [4];
    logic [1:0]            r_idx;
    logic [1:0]            w_idx_nxt;
    logic [1:0]            w_load_idx;
    logic [15:0]           w_load_val;
    logic [15:0]           r_sample_data;
    logic [15:0]           r_fir_coeff;
    logic                  r_overrun;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;
    logic                  w_load_entry;

    assign w_full = (r_count == c_FULL);
    // A pop on the same edge frees the slot, so a write while full is still taken.
    assign w_push = in_valid && (!w_full || w_pop);
    assign w_drop = in_valid && w_full && !w_pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_idx_nxt    = r_idx;
        w_pop        = 1'b0;
        w_load_entry = 1'b0;
        w_load_idx   = r_idx;
        case (r_state)
            S_IDLE: begin
                if (coeff_go) begin
                    w_state_nxt  = S_LOAD;
                    w_idx_nxt    = 2'd0;
                    w_load_entry = 1'b1;
                    w_load_idx   = 2'd0;
                end else if ((r_count != '0) && !modwait) begin
                    w_state_nxt = S_ISSUE;
                    w_pop       = 1'b1;
                end
            end
            S_LOAD: begin
                if (modwait) w_state_nxt = S_LWAIT;
            end
            S_LWAIT: begin
                if (!modwait) begin
                    if (r_idx == 2'd3) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt  = S_LOAD;
                        w_idx_nxt    = r_idx + 2'd1;
                        w_load_entry = 1'b1;
                        w_load_idx   = r_idx + 2'd1;
                    end
                end
            end
            S_ISSUE: begin
                if (modwait) w_state_nxt = S_SWAIT;
            end
            S_SWAIT: begin
                if (!modwait) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // A shadow write landing on the same edge as the slot is captured wins.
    assign w_load_val = (coeff_wr && (coeff_idx == w_load_idx)) ? coeff_data : r_slot[w_load_idx];

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= in_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) r_slot[i] <= '0;
        end else if (coeff_wr) begin
            r_slot[coeff_idx] <= coeff_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sample_data <= '0;
            r_fir_coeff   <= '0;
            r_overrun     <= 1'b0;
        end else begin
            if (w_pop)        r_sample_data <= r_mem[r_rd_ptr];
            if (w_load_entry) r_fir_coeff   <= w_load_val;
            if (w_drop)       r_overrun     <= 1'b1;
        end
    end

`ifdef SAMPLE_FEEDER_DROP_CNT_EN
    logic [7:0] r_drop_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drop_cnt <= 8'd0;
        end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    assign drop_count = r_drop_cnt;
`else
    assign drop_count = 8'd0;
`endif

    assign in_ready        = !w_full;
    assign fill_level      = r_count;
    assign sample_data     = r_sample_data;
    assign fir_coefficient = r_fir_coeff;
    assign data_ready      = (r_state == S_ISSUE);
    assign load_coeff      = (r_state == S_LOAD);
    assign coeff_busy      = (r_state == S_LOAD) || (r_state == S_LWAIT);
    assign overrun         = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_sample_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_sample_feeder
// Description : Scoreboard bench for sample_feeder with a randomized
//               downstream filter model and transaction-level reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sample_feeder;

    localparam int DEPTH = 8;
`ifdef SAMPLE_FEEDER_DROP_CNT_EN
    localparam int c_EXP_DROP = 3;
`else
    localparam int c_EXP_DROP = 0;
`endif

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   in_valid = 1'b0;
    logic [15:0]            in_data = '0;
    logic                   in_ready;
    logic                   coeff_wr = 1'b0;
    logic [1:0]             coeff_idx = '0;
    logic [15:0]            coeff_data = '0;
    logic                   coeff_go = 1'b0;
    logic                   modwait = 1'b0;
    logic [15:0]            sample_data;
    logic [15:0]            fir_coefficient;
    logic                   data_ready;
    logic                   load_coeff;
    logic [$clog2(DEPTH):0] fill_level;
    logic                   coeff_busy;
    logic                   overrun;
    logic [7:0]             drop_count;

    sample_feeder #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .coeff_wr(coeff_wr), .coeff_idx(coeff_idx), .coeff_data(coeff_data),
        .coeff_go(coeff_go), .modwait(modwait),
        .sample_data(sample_data), .fir_coefficient(fir_coefficient),
        .data_ready(data_ready), .load_coeff(load_coeff),
        .fill_level(fill_level), .coeff_busy(coeff_busy),
        .overrun(overrun), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int          n_issues = 0;
    int          n_loads = 0;
    bit          auto_filter = 1'b0;
    logic [15:0] exp_q [$];
    logic [15:0] m_slot [4];
    logic [1:0]  k_idx = '0;
    bit          prev_dr = 1'b0;
    bit          prev_lc = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_sample(input logic [15:0] d, input bit accepted);
        in_valid = 1'b1;
        in_data  = d;
        if (accepted) exp_q.push_back(d);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic put_coeff(input logic [1:0] idx, input logic [15:0] d);
        coeff_wr   = 1'b1;
        coeff_idx  = idx;
        coeff_data = d;
        tick();
        coeff_wr   = 1'b0;
    endtask

    task automatic drain(input string nm);
        int i = 0;
        while ((exp_q.size() != 0 || fill_level != '0 || data_ready || coeff_busy) && i < 3000) begin
            tick();
            i++;
        end
        chk(nm, int'(i < 3000), 1);
        repeat (6) tick();
    endtask

    task automatic wait_coeff_done(input string nm);
        int i = 0;
        while (coeff_busy && i < 500) begin
            tick();
            i++;
        end
        chk(nm, int'(coeff_busy), 0);
    endtask

    // Shadow-slot reference: a write lands on the clock edge it is sampled.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) m_slot[i] = '0;
        end else if (coeff_wr) begin
            m_slot[coeff_idx] = coeff_data;
        end
    end

    // Downstream filter: answers each request with a busy pulse of random timing.
    initial begin
        forever begin
            @(negedge clk);
            if (auto_filter && !rst && (data_ready || load_coeff) && !modwait) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                modwait = 1'b1;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                modwait = 1'b0;
            end
        end
    end

    // Monitor: every new request is one transaction checked against the model.
    always @(negedge clk) begin
        if (rst) begin
            k_idx   = '0;
            prev_dr = 1'b0;
            prev_lc = 1'b0;
        end else begin
            if (data_ready && !prev_dr) begin
                n_issues++;
                chk("excl_on_issue", int'(load_coeff), 0);
                if (exp_q.size() == 0) chk("unexpected_issue", 1, 0);
                else chk("sample_data", int'(sample_data), int'(exp_q.pop_front()));
            end
            if (load_coeff && !prev_lc) begin
                n_loads++;
                chk("excl_on_load", int'(data_ready), 0);
                chk("fir_coefficient", int'(fir_coefficient), int'(m_slot[k_idx]));
                k_idx = k_idx + 2'd1;
            end
            prev_dr = data_ready;
            prev_lc = load_coeff;
        end
    end

    task automatic check_reset_outputs(input string nm);
        chk({nm, "_fill"}, int'(fill_level), 0);
        chk({nm, "_in_ready"}, int'(in_ready), 1);
        chk({nm, "_data_ready"}, int'(data_ready), 0);
        chk({nm, "_load_coeff"}, int'(load_coeff), 0);
        chk({nm, "_coeff_busy"}, int'(coeff_busy), 0);
        chk({nm, "_overrun"}, int'(overrun), 0);
        chk({nm, "_drop_count"}, int'(drop_count), 0);
        chk({nm, "_sample_data"}, int'(sample_data), 0);
        chk({nm, "_fir_coefficient"}, int'(fir_coefficient), 0);
    endtask

    initial begin
        int base_i;
        int base_l;

        tick();
        check_reset_outputs("rst_init");
        tick();
        rst = 1'b0;
        tick();

        // Minimum latency: write into empty FIFO, request two cycles later.
        put_sample(16'h1234, 1'b1);
        chk("lat_dr_cycle1", int'(data_ready), 0);
        chk("lat_fill_cycle1", int'(fill_level), 1);
        tick();
        chk("lat_dr_cycle2", int'(data_ready), 1);
        chk("lat_sample", int'(sample_data), 16'h1234);
        modwait = 1'b1;
        tick();
        chk("swait_dr", int'(data_ready), 0);
        modwait = 1'b0;
        tick();
        chk("idle_dr", int'(data_ready), 0);
        chk("idle_fill", int'(fill_level), 0);

        // Four-coefficient load sequence.
        for (int i = 0; i < 4; i++) put_coeff(2'(i), 16'(i + 1));
        auto_filter = 1'b1;
        base_l = n_loads;
        coeff_go = 1'b1;
        tick();
        coeff_go = 1'b0;
        chk("coeff_busy_start", int'(coeff_busy), 1);
        wait_coeff_done("coeff_seq_done");
        chk("coeff_load_count", n_loads - base_l, 4);
        drain("coeff_seq_settle");

        // Overflow with the filter held busy.
        auto_filter = 1'b0;
        modwait = 1'b1;
        for (int i = 0; i < DEPTH; i++) put_sample(16'hA000 + 16'(i), 1'b1);
        chk("full_overrun_clear", int'(overrun), 0);
        for (int i = 0; i < 3; i++) put_sample(16'hD000 + 16'(i), 1'b0);
        chk("ovf_fill", int'(fill_level), DEPTH);
        chk("ovf_in_ready", int'(in_ready), 0);
        chk("ovf_overrun", int'(overrun), 1);
        chk("ovf_drop_count", int'(drop_count), c_EXP_DROP);

        // Push and pop on the same edge while full.
        modwait = 1'b0;
        put_sample(16'hB00B, 1'b1);
        chk("pp_fill", int'(fill_level), DEPTH);
        chk("pp_drop_count", int'(drop_count), c_EXP_DROP);
        chk("pp_overrun_sticky", int'(overrun), 1);
        auto_filter = 1'b1;
        drain("pp_drain");
        chk("pp_queue_empty", exp_q.size(), 0);

        // coeff_go with two samples queued: coefficients go first.
        auto_filter = 1'b0;
        modwait = 1'b1;
        put_sample(16'h5A01, 1'b1);
        put_sample(16'h5A02, 1'b1);
        chk("prio_fill", int'(fill_level), 2);
        base_i = n_issues;
        base_l = n_loads;
        coeff_go = 1'b1;
        modwait = 1'b0;
        auto_filter = 1'b1;
        tick();
        coeff_go = 1'b0;
        put_coeff(2'd3, 16'hBEEF);
        wait_coeff_done("prio_coeff_done");
        chk("prio_no_issue_during_load", n_issues - base_i, 0);
        chk("prio_loads", n_loads - base_l, 4);
        chk("prio_fill_after_load", int'(fill_level), 2);
        drain("prio_drain");
        chk("prio_issues", n_issues - base_i, 2);

        // Randomized traffic with shadow-slot updates.
        for (int n = 0; n < 300; n++) begin
            in_valid = (exp_q.size() < DEPTH) && ($urandom_range(0, 1) == 1);
            in_data  = 16'($urandom);
            if (in_valid) exp_q.push_back(in_data);
            coeff_wr   = ($urandom_range(0, 4) == 0);
            coeff_idx  = 2'($urandom_range(0, 3));
            coeff_data = 16'($urandom);
            tick();
        end
        in_valid = 1'b0;
        coeff_wr = 1'b0;
        drain("rand_drain");
        chk("rand_drop_stable", int'(drop_count), c_EXP_DROP);

        // Reset during LWAIT with five samples queued.
        auto_filter = 1'b0;
        modwait = 1'b1;
        for (int i = 0; i < 5; i++) put_sample(16'hC000 + 16'(i), 1'b1);
        chk("lw_fill", int'(fill_level), 5);
        coeff_go = 1'b1;
        tick();
        coeff_go = 1'b0;
        chk("lw_load", int'(load_coeff), 1);
        tick();
        chk("lw_in_lwait", int'(coeff_busy), 1);
        rst = 1'b1;
        exp_q.delete();
        #1;
        check_reset_outputs("rst_mid");
        tick();
        rst = 1'b0;
        modwait = 1'b0;
        auto_filter = 1'b1;
        base_i = n_issues;
        base_l = n_loads;
        repeat (20) tick();
        chk("post_rst_no_issue", n_issues - base_i, 0);
        chk("post_rst_no_load", n_loads - base_l, 0);
        put_sample(16'hA5A5, 1'b1);
        drain("post_rst_drain");
        chk("post_rst_issue", n_issues - base_i, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/sample_feeder.md
SAMPLE_FEEDER -- requirements
Module: sample_feeder

Interface
REQ-001 SHALL have parameter DEPTH, default 8, sample FIFO depth (power of 2, 4..64).
REQ-002 SHALL have ports:
- clk  in  1  system clock, rising-edge
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  upstream sample write strobe
- in_data  in  16  upstream sample
- in_ready  out  1  FIFO not full
- coeff_wr  in  1  write coeff_data into coefficient shadow slot coeff_idx
- coeff_idx  in  2  shadow slot index 0..3
- coeff_data  in  16  coefficient value
- coeff_go  in  1  start the 4-coefficient load sequence
- modwait  in  1  filter busy, from downstream filter
- sample_data  out  16  sample presented to filter
- fir_coefficient  out  16  coefficient presented to filter
- data_ready  out  1  sample-valid request to filter
- load_coeff  out  1  coefficient-valid request to filter
- fill_level  out  $clog2(DEPTH)+1  FIFO occupancy
- coeff_busy  out  1  coefficient sequence in progress
- overrun  out  1  sticky, write attempted while full
- drop_count  out  8  dropped-sample counter

Function
REQ-003 FIFO SHALL accept in_data on a clk edge when in_valid=1 and fill_level<DEPTH; pointers SHALL wrap modulo DEPTH.
REQ-004 in_ready SHALL equal (fill_level<DEPTH), combinational from registered state.
REQ-005 in_valid=1 while full SHALL drop the sample, leave FIFO unchanged, and set overrun (held until reset).
REQ-006 Shadow slots SHALL be written on coeff_wr regardless of FSM state; a write during LOAD/LWAIT SHALL take effect for slots not yet presented.
REQ-007 FSM states SHALL be IDLE, LOAD, LWAIT, ISSUE, SWAIT.
REQ-008 IDLE: coeff_go=1 -> LOAD with index=0 (priority over samples); else fill_level>0 and modwait=0 -> ISSUE, popping the FIFO head into sample_data on that edge.
REQ-009 LOAD: fir_coefficient=slot[index], load_coeff=1; when modwait=1 sampled -> LWAIT, load_coeff=0 next cycle.
REQ-010 LWAIT: on modwait=0, if index=3 -> IDLE, else index+1 -> LOAD.
REQ-011 ISSUE: data_ready=1, sample_data held; when modwait=1 sampled -> SWAIT, data_ready=0 next cycle.
REQ-012 SWAIT: on modwait=0 -> IDLE; the next issue SHALL occur no earlier than the following cycle.
REQ-013 Minimum latency from write into an empty FIFO with filter idle to data_ready=1 SHALL be 2 cycles.
REQ-014 Simultaneous push and pop SHALL leave fill_level unchanged; push while full and pop on the same edge SHALL be accepted (no drop).
REQ-015 coeff_busy SHALL be 1 in LOAD and LWAIT; coeff_go outside IDLE SHALL be ignored.
REQ-016 sample_data and fir_coefficient SHALL be registered and SHALL hold their last values outside ISSUE/LOAD.
REQ-017 data_ready and load_coeff SHALL never be 1 in the same cycle.

Reset
REQ-018 rst=1 SHALL asynchronously force: FSM=IDLE, FIFO empty (fill_level=0, in_ready=1), index=0, all shadow slots=0, sample_data=0, fir_coefficient=0, data_ready=0, load_coeff=0, coeff_busy=0, overrun=0, drop_count=0.
REQ-019 Reset mid-sequence SHALL abort with no further request pulses; buffered samples SHALL be discarded.

Configuration
REQ-020 With SAMPLE_FEEDER_DROP_CNT_EN defined, drop_count SHALL increment on each dropped sample and saturate at 255; without it, drop_count SHALL be constant 0 and no counter logic SHALL be built; overrun SHALL behave identically in both builds.

Verification
REQ-021 The bench SHALL cover:
- Write 0x1234 to empty FIFO, modwait=0 -> data_ready=1 two cycles later, sample_data=0x1234; modwait pulses 1 then 0 -> data_ready=0, FSM back to IDLE.
- Write slots 0..3 = 0x0001,0x0002,0x0003,0x0004, pulse coeff_go -> four load_coeff handshakes presenting 0x0001..0x0004 in order; coeff_busy=0 after the fourth modwait fall.
- Hold modwait=1, write DEPTH+3 samples -> fill_level=DEPTH, in_ready=0, overrun=1, drop_count=3 (macro on) / 0 (macro off).
- FIFO full, push and pop on the same edge -> fill_level stays DEPTH, no drop, data order preserved across the pointer wrap.
- coeff_go while 2 samples are queued -> coefficient sequence runs first, then both samples issue in FIFO order.
- Assert rst during LWAIT with 5 queued -> all outputs at reset values immediately; no data_ready or load_coeff after release until new input arrives.
